// File: rtl/encoder_8b10b_rd_if.sv
// Stream bundle for the multi-lane 8b/10b encoder: byte/K beats in, 10-bit symbols out.
interface encoder_8b10b_rd_if #(
  parameter int LANES = 1
);
  logic [8*LANES-1:0]  i_data;
  logic [LANES-1:0]    i_k;
  logic                i_valid;
  logic                o_ready;
  logic [10*LANES-1:0] o_data;
  logic [LANES-1:0]    o_rd;
  logic [LANES-1:0]    o_kerr;
  logic                o_valid;
  logic                i_ready;

  modport slave (
    input  i_data, i_k, i_valid, i_ready,
    output o_ready, o_data, o_rd, o_kerr, o_valid
  );

  modport master (
    output i_data, i_k, i_valid, i_ready,
    input  o_ready, o_data, o_rd, o_kerr, o_valid
  );
endinterface

// File: rtl/encoder_8b10b_rd.sv
// Registered multi-lane 8b/10b encoder with running-disparity chaining lane 0 -> LANES-1.
// Optional ENC8B10B_KERR_EN: flag K requests outside the legal K list on o_kerr.
module encoder_8b10b_rd #(
  parameter int LANES = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  encoder_8b10b_rd_if.slave   bus
);

  // 6b codes in the RD- column, written abcdei with a as the MSB
  function automatic logic [5:0] enc6(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 4b codes in the RD- column, written fghj with f as the MSB (primary .7)
  function automatic logic [3:0] enc4(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;  3'd1: c = 4'b1001;  3'd2: c = 4'b0101;  3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;  3'd5: c = 4'b1010;  3'd6: c = 4'b0110;  default: c = 4'b1110;
    endcase
    return c;
  endfunction

  function automatic logic is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE);
  endfunction

  // Returns {rd_out, {j,h,g,f,i,e,d,c,b,a}}
  function automatic logic [10:0] encode_sym(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic       kv, k28, unb6, rd6, alt;
    logic [5:0] c6;
    logic [3:0] c4;
    logic [9:0] s;
    x    = b[4:0];
    y    = b[7:5];
    kv   = k && is_legal_k(b);
    k28  = kv && (x == 5'd28);
    c6   = k28 ? 6'b001111 : enc6(x);
    unb6 = ($countones(c6) != 3);
    // D.7 is balanced but still alternates with disparity
    if (rd && (unb6 || (x == 5'd7))) c6 = ~c6;
    rd6  = rd ^ unb6;
    // Every legal K.x.7 uses the alternate 4b so the comma property holds
    alt  = (y == 3'd7) && (kv ||
           (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
           ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
    c4   = alt ? 4'b0111 : enc4(y);
    if (rd6 && (($countones(c4) != 2) || (y == 3'd3))) c4 = ~c4;
    if (k28 && !rd6 && ((y == 3'd1) || (y == 3'd2) || (y == 3'd5) || (y == 3'd6))) c4 = ~c4;
    s = {c6, c4};
    return {rd6 ^ ($countones(c4) != 2),
            s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7], s[8], s[9]};
  endfunction

  logic                valid_q;
  logic [10*LANES-1:0] data_q, data_d;
  logic [LANES-1:0]    rdo_q, rdo_d;
  logic [LANES-1:0]    kerr_q, kerr_d;
  logic                rd_q, rd_d;
  logic                accept;

  assign bus.o_ready = !valid_q || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;

  always_comb begin
    logic        rd_run;
    logic [10:0] res;
    data_d = '0;
    rdo_d  = '0;
    kerr_d = '0;
    rd_run = rd_q;
    res    = '0;
    for (int n = 0; n < LANES; n++) begin
      res                = encode_sym(bus.i_data[8*n +: 8], bus.i_k[n], rd_run);
      data_d[10*n +: 10] = res[9:0];
      rdo_d[n]           = res[10];
      rd_run             = res[10];
`ifdef ENC8B10B_KERR_EN
      kerr_d[n]          = bus.i_k[n] && !is_legal_k(bus.i_data[8*n +: 8]);
`endif
    end
    rd_d = rd_run;
  end

  // Output stage: single register, holds under backpressure, RD advances only on accept
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rdo_q   <= '0;
      kerr_q  <= '0;
      rd_q    <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
      rdo_q   <= rdo_d;
      kerr_q  <= kerr_d;
      rd_q    <= rd_d;
    end else if (bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;
  assign bus.o_rd    = rdo_q;
  assign bus.o_kerr  = kerr_q;

endmodule

// File: tb/tb_encoder_8b10b_rd.sv
// Bench for encoder_8b10b_rd: table-driven 8b/10b reference, one- and two-lane DUTs, random traffic.
module tb_encoder_8b10b_rd;

  localparam logic [5:0] D6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] D6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] D4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] D4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [7:0] KBYTE [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                                        8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [9:0] KNEG [12] = '{
    10'b001111_0100, 10'b001111_1001, 10'b001111_0101, 10'b001111_0011, 10'b001111_0010,
    10'b001111_1010, 10'b001111_0110, 10'b001111_1000, 10'b111010_1000, 10'b110110_1000,
    10'b101110_1000, 10'b011110_1000};
  localparam logic [9:0] KPOS [12] = '{
    10'b110000_1011, 10'b110000_0110, 10'b110000_1010, 10'b110000_1100, 10'b110000_1101,
    10'b110000_0101, 10'b110000_1001, 10'b110000_0111, 10'b000101_0111, 10'b001001_0111,
    10'b010001_0111, 10'b100001_0111};
`ifdef ENC8B10B_KERR_EN
  localparam logic KE = 1'b1;
`else
  localparam logic KE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic valid, ready;
  logic [7:0] d0, d1;
  logic k0, k1;
  always #5 clk = ~clk;

  encoder_8b10b_rd_if #(.LANES(1)) b1 ();
  encoder_8b10b_rd_if #(.LANES(2)) b2 ();
  assign b1.i_data = d0;        assign b1.i_k = k0;
  assign b1.i_valid = valid;    assign b1.i_ready = ready;
  assign b2.i_data = {d1, d0};  assign b2.i_k = {k1, k0};
  assign b2.i_valid = valid;    assign b2.i_ready = ready;

  encoder_8b10b_rd #(.LANES(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  encoder_8b10b_rd #(.LANES(2)) u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));

  int checks = 0;
  int errors = 0;
  logic run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kidx(input logic [7:0] b);
    int r = -1;
    for (int i = 0; i < 12; i++) if (KBYTE[i] == b) r = i;
    return r;
  endfunction

  // Reference: full-column lookups, disparity from ones count; returns {rd_out, {j..a}}
  function automatic logic [10:0] menc(input logic [7:0] b, input logic k, input logic rd);
    int x, y, ki, ones;
    logic [5:0] s6;
    logic [3:0] s4;
    logic [9:0] s, o;
    logic rd6, rdo;
    x  = int'(b[4:0]);
    y  = int'(b[7:5]);
    ki = k ? kidx(b) : -1;
    if (ki >= 0) s = rd ? KPOS[ki] : KNEG[ki];
    else begin
      s6   = rd ? D6P[x] : D6N[x];
      ones = $countones(s6);
      rd6  = (ones > 3) ? 1'b1 : (ones < 3) ? 1'b0 : rd;
      if (y == 7 && ((!rd && (x == 17 || x == 18 || x == 20)) || (rd && (x == 11 || x == 13 || x == 14))))
        s4 = rd6 ? 4'b1000 : 4'b0111;
      else
        s4 = rd6 ? D4P[y] : D4N[y];
      s = {s6, s4};
    end
    ones = $countones(s);
    rdo  = (ones > 5) ? 1'b1 : (ones < 5) ? 1'b0 : rd;
    for (int i = 0; i < 10; i++) o[i] = s[9-i];
    return {rdo, o};
  endfunction

  logic        m_valid, m_zero;
  logic [9:0]  m1_data;
  logic        m1_rd, m1_kerr, m1_st;
  logic [19:0] m2_data;
  logic [1:0]  m2_rd, m2_kerr;
  logic        m2_st;

  always @(posedge clk) begin
    logic [10:0] r0, r1, r2;
    if (!rst_n) begin
      m_valid <= 1'b0; m_zero <= 1'b1;
      m1_data <= '0; m1_rd <= 1'b0; m1_kerr <= 1'b0; m1_st <= 1'b0;
      m2_data <= '0; m2_rd <= '0;   m2_kerr <= '0;   m2_st <= 1'b0;
    end else if (valid && (!m_valid || ready)) begin
      r0 = menc(d0, k0, m1_st);
      r1 = menc(d0, k0, m2_st);
      r2 = menc(d1, k1, r1[10]);
      m1_data <= r0[9:0]; m1_rd <= r0[10]; m1_st <= r0[10];
      m1_kerr <= KE && k0 && (kidx(d0) < 0);
      m2_data <= {r2[9:0], r1[9:0]}; m2_rd <= {r2[10], r1[10]}; m2_st <= r2[10];
      m2_kerr <= {KE && k1 && (kidx(d1) < 0), KE && k0 && (kidx(d0) < 0)};
      m_valid <= 1'b1; m_zero <= 1'b0;
    end else if (ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("valid1", 32'(b1.o_valid), 32'(m_valid));
      chk("valid2", 32'(b2.o_valid), 32'(m_valid));
      chk("ready1", 32'(b1.o_ready), 32'(!m_valid || ready));
      chk("ready2", 32'(b2.o_ready), 32'(!m_valid || ready));
      if (m_valid || m_zero) begin
        chk("data1", 32'(b1.o_data), 32'(m1_data));
        chk("rd1",   32'(b1.o_rd),   32'(m1_rd));
        chk("kerr1", 32'(b1.o_kerr), 32'(m1_kerr));
        chk("data2", 32'(b2.o_data), 32'(m2_data));
        chk("rd2",   32'(b2.o_rd),   32'(m2_rd));
        chk("kerr2", 32'(b2.o_kerr), 32'(m2_kerr));
      end
    end
  end

  task automatic beat(input logic v, input logic [7:0] a, input logic ka,
                      input logic [7:0] b, input logic kb, input logic r);
    valid = v; d0 = a; k0 = ka; d1 = b; k1 = kb; ready = r;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; ready = 1'b0; d0 = '0; d1 = '0; k0 = 1'b0; k1 = 1'b0;
    @(posedge clk); #1;
    run_cmp = 1'b1;
    chk("rst_valid", 32'(b1.o_valid), 32'd0);
    chk("rst_data",  32'(b1.o_data),  32'd0);
    chk("rst_rd",    32'(b1.o_rd),    32'd0);
    chk("rst_kerr",  32'(b1.o_kerr),  32'd0);
    chk("rst_ready", 32'(b1.o_ready), 32'd1);
    rst_n = 1'b1;

    beat(1, 8'hBC, 1, 8'hBC, 1, 1);
    chk("k285_a", 32'(b1.o_data), 32'h17C);
    chk("k285_a_rd", 32'(b1.o_rd), 32'd1);
    chk("two_lane_data", 32'(b2.o_data), {12'd0, 10'h283, 10'h17C});
    chk("two_lane_rd", 32'(b2.o_rd), 32'd1);
    beat(1, 8'hBC, 1, 8'hBC, 1, 1);
    chk("k285_b", 32'(b1.o_data), 32'h283);
    chk("k285_b_rd", 32'(b1.o_rd), 32'd0);
    chk("two_lane_next_l0", 32'(b2.o_data[9:0]), 32'h17C);
    beat(1, 8'hBC, 1, 8'($urandom), 0, 1);
    chk("k285_c", 32'(b1.o_data), 32'h17C);
    chk("k285_c_rd", 32'(b1.o_rd), 32'd1);
    beat(1, 8'hBC, 1, 8'($urandom), 0, 1);
    chk("k285_d", 32'(b1.o_data), 32'h283);

    beat(1, 8'h00, 0, 8'($urandom), 0, 1);
    chk("d0_0", 32'(b1.o_data), 32'h0B9);
    chk("d0_0_rd", 32'(b1.o_rd), 32'd0);
    beat(1, 8'hB5, 0, 8'($urandom), 0, 1);
    chk("d21_5", 32'(b1.o_data), 32'h155);
    chk("d21_5_rd", 32'(b1.o_rd), 32'd0);

    beat(1, 8'hBC, 1, 8'($urandom), 0, 1);
    chk("bp_first", 32'(b1.o_data), 32'h17C);
    for (int i = 0; i < 4; i++) begin
      beat(1, 8'h00, 0, 8'($urandom), 0, 0);
      chk("bp_hold_data", 32'(b1.o_data), 32'h17C);
      chk("bp_hold_ready", 32'(b1.o_ready), 32'd0);
    end
    beat(1, 8'h00, 0, 8'($urandom), 0, 1);
    chk("bp_release", 32'(b1.o_data), 32'h346);
    chk("bp_release_rd", 32'(b1.o_rd), 32'd1);

    beat(1, 8'h00, 1, 8'($urandom), 0, 1);
    chk("badk_rdp_data", 32'(b1.o_data), 32'h346);
    chk("badk_rdp_kerr", 32'(b1.o_kerr), 32'(KE));

    beat(1, 8'hBC, 1, 8'($urandom), 0, 1);
    chk("pre_rst_a", 32'(b1.o_data), 32'h283);
    beat(1, 8'hBC, 1, 8'($urandom), 0, 1);
    chk("pre_rst_b", 32'(b1.o_data), 32'h17C);
    rst_n = 1'b0;
    beat(0, 8'h00, 0, 8'h00, 0, 0);
    chk("mid_rst_valid", 32'(b1.o_valid), 32'd0);
    rst_n = 1'b1;
    beat(1, 8'hBC, 1, 8'($urandom), 0, 1);
    chk("post_rst_k285", 32'(b1.o_data), 32'h17C);
    beat(1, 8'hBC, 1, 8'($urandom), 0, 1);
    beat(1, 8'h00, 1, 8'($urandom), 0, 1);
    chk("badk_data", 32'(b1.o_data), 32'h0B9);
    chk("badk_kerr", 32'(b1.o_kerr), 32'(KE));
    beat(0, 8'h00, 0, 8'h00, 0, 1);
    chk("drain_valid", 32'(b1.o_valid), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] a, b;
      logic ka, kb;
      ka = ($urandom_range(0, 3) == 0);
      kb = ($urandom_range(0, 3) == 0);
      a  = (ka && $urandom_range(0, 1) == 1) ? KBYTE[$urandom_range(0, 11)] : 8'($urandom);
      b  = (kb && $urandom_range(0, 1) == 1) ? KBYTE[$urandom_range(0, 11)] : 8'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      beat(($urandom_range(0, 9) < 7), a, ka, b, kb, ($urandom_range(0, 9) < 7));
    end
    rst_n = 1'b1;
    beat(0, 8'h00, 0, 8'h00, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
